// File: rtl/mem_responder.sv
// mem_responder: wait-state memory slave answering level-held READ/WRITE strobes with a one-cycle READY pulse.
// Optional feature macro: MEM_RESP_ERR_EN (out-of-range and illegal-request error reporting on o_err).
module mem_responder #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 26,
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_read,
  input  logic                  i_write,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_data_in,
  output logic [DATA_WIDTH-1:0] o_data_out,
  output logic                  o_ready,
  output logic                  o_err
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = WAIT_CYCLES > 1 ? $clog2(WAIT_CYCLES) : 1;
  typedef enum logic [1:0] {IDLE, BUSY, DONE, RELEASE} state_t;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  state_t                r_state;
  logic [CW-1:0]         r_cnt;
  logic                  r_op_wr;
  logic [IW-1:0]         r_idx;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  w_req_ok;
  logic                  w_idle;
  logic                  w_acc;
  logic                  w_wr;
  logic [IW-1:0]         w_idx;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic                  w_block;
  assign w_req_ok = i_read ^ i_write;
  assign w_idle   = r_state == IDLE;
  // with zero wait states the access happens on the accept edge, so the live inputs are used
  assign w_acc    = (w_idle && w_req_ok && WAIT_CYCLES == 0) ||
                    (r_state == BUSY && r_cnt == CW'(WAIT_CYCLES - 1));
  assign w_wr     = w_idle ? i_write : r_op_wr;
  assign w_idx    = w_idle ? i_addr[IW-1:0] : r_idx;
  assign w_wdata  = w_idle ? i_data_in : r_wdata;
`ifdef MEM_RESP_ERR_EN
  logic r_oor;
  logic w_oor_in;
  logic w_illegal;
  assign w_oor_in  = |(i_addr >> IW);
  assign w_illegal = i_read & i_write;
  assign w_block   = w_idle ? w_oor_in : r_oor;
  // remember whether the accepted address was outside the implemented array
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_oor <= 1'b0;
    else if (w_idle && w_req_ok) r_oor <= w_oor_in;
  end
  // error flag: out-of-range with READY, or an illegal dual-strobe request seen in IDLE
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) o_err <= 1'b0;
    else o_err <= (r_state == DONE && r_oor) || (w_idle && w_illegal);
  end
`else
  assign w_block = 1'b0;
  assign o_err   = 1'b0;
`endif
  // array commit; contents survive reset and a reset on the access edge cancels the write
  always_ff @(posedge i_clk) begin
    if (i_rst_n && w_acc && w_wr && !w_block) r_mem[w_idx] <= w_wdata;
  end
  // request FSM with registered READY and read data
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_op_wr    <= 1'b0;
      r_idx      <= '0;
      r_wdata    <= '0;
      o_ready    <= 1'b0;
      o_data_out <= '0;
    end else begin
      o_ready <= r_state == DONE;
      if (w_acc && !w_wr) o_data_out <= w_block ? '0 : r_mem[w_idx];
      case (r_state)
        IDLE: if (w_req_ok) begin
          r_op_wr <= i_write;
          r_idx   <= i_addr[IW-1:0];
          r_wdata <= i_data_in;
          r_cnt   <= '0;
          r_state <= WAIT_CYCLES == 0 ? DONE : BUSY;
        end
        BUSY: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_acc) r_state <= DONE;
        end
        DONE:    r_state <= RELEASE;
        RELEASE: if (!i_read && !i_write) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
